// File: rtl/button_pkg.sv
// Shared button definitions: gesture FSM state encoding and default tick counts.
package button_pkg;

  localparam int unsigned DEFAULT_COUNTWIDTH   = 17;
  localparam int unsigned DEFAULT_LONG_TICKS   = 50000;
  localparam int unsigned DEFAULT_DCLICK_TICKS = 25000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } btn_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short / double / long gesture pulses
// plus a held level, with all timing counted in ticks of an external strobe.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned COUNTWIDTH    = DEFAULT_COUNTWIDTH,
  parameter int unsigned LONG_TICKS    = DEFAULT_LONG_TICKS,
  parameter int unsigned DCLICK_TICKS  = DEFAULT_DCLICK_TICKS,
  parameter logic        PRESSED_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic held_o
);

  if (LONG_TICKS < 2 || DCLICK_TICKS < 2 ||
      64'(LONG_TICKS) >= (64'd1 << COUNTWIDTH) ||
      64'(DCLICK_TICKS) >= (64'd1 << COUNTWIDTH)) begin : g_param_err
    $error("button_event_decoder: tick counts must be >= 2 and fit in COUNTWIDTH");
  end

  // The press tick itself is the first pressed tick, so the long limit sits one lower.
  localparam logic [COUNTWIDTH-1:0] LONG_LAST   = COUNTWIDTH'(LONG_TICKS - 2);
  localparam logic [COUNTWIDTH-1:0] DCLICK_LAST = COUNTWIDTH'(DCLICK_TICKS - 1);

  logic                  btn_sync;
  logic                  pressed;
  btn_state_e            state_q, state_d;
  logic [COUNTWIDTH-1:0] cnt_q, cnt_d;
  logic                  short_c, double_c, long_c;

  sync2 #(
    .RESET_VAL(~PRESSED_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_i),
    .q    (btn_sync)
  );

  assign pressed = (btn_sync == PRESSED_LEVEL);

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gesture FSM, evaluated only on tick cycles; a release/press beats the limit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_c  = 1'b0;
    double_c = 1'b0;
    long_c   = 1'b0;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pressed) state_d = ST_PRESS1;
        end
        ST_PRESS1: begin
          if (!pressed) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d = ST_LONG;
            cnt_d   = '0;
            long_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNTWIDTH'(1);
          end
        end
        ST_GAP: begin
          if (pressed) begin
            state_d = ST_PRESS2;
            cnt_d   = '0;
          end else if (cnt_q == DCLICK_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            short_c = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNTWIDTH'(1);
          end
        end
        ST_PRESS2: begin
          if (!pressed) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            double_c = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d = ST_LONG;
            cnt_d   = '0;
            long_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + COUNTWIDTH'(1);
          end
        end
        ST_LONG: begin
          cnt_d = '0;
          if (!pressed) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output registers; held follows the next state so it rises with long_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_o  <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      held_o   <= 1'b0;
    end else begin
      short_o  <= short_c;
      double_o <= double_c;
      long_o   <= long_c;
      held_o   <= (state_d == ST_LONG);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: per-tick vector table plus
// hand-written reset and continuous-tick sequences.
module tb_button_event_decoder;

  localparam logic [3:0] E_NONE = 4'b0000;
  localparam logic [3:0] E_S    = 4'b1000;
  localparam logic [3:0] E_D    = 4'b0100;
  localparam logic [3:0] E_LH   = 4'b0011;
  localparam logic [3:0] E_H    = 4'b0001;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic btn;
  logic short_o, double_o, long_o, held_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        prev_held = 1'b0;

  typedef struct {
    logic       p;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  button_event_decoder #(
    .COUNTWIDTH   (17),
    .LONG_TICKS   (8),
    .DCLICK_TICKS (4),
    .PRESSED_LEVEL(1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_i  (tick),
    .btn_i   (btn),
    .short_o (short_o),
    .double_o(double_o),
    .long_o  (long_o),
    .held_o  (held_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {short_o, double_o, long_o, held_o};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: {short,double,long,held} got %b expected %b", name, act, exp);
  endtask

  task automatic add(input logic p, input logic [3:0] exp, input string name);
    vec_t v;
    v.p = p;
    v.exp = exp;
    v.name = name;
    tbl.push_back(v);
  endtask

  // One 4-clk tick period, entered and left on a negedge with tick low.
  task automatic apply_tick(input logic p, input logic [3:0] exp, input string name);
    btn  = ~p;
    tick = 1'b0;
    @(posedge clk); #1;
    check({name, "_prev_pulse_end"}, outs(), {3'b000, prev_held});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1;
    check(name, outs(), exp);
    @(negedge clk);
    tick = 1'b0;
    prev_held = exp[0];
  endtask

  task automatic do_reset(input logic p);
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b0;
    btn   = ~p;
    #1;
    check("in_reset", outs(), E_NONE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_cycle_after_reset", outs(), E_NONE);
    @(negedge clk);
    prev_held = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    btn   = 1'b1;

    // Single short click: short 4 ticks after the release tick.
    for (int i = 0; i < 3; i++) add(1'b1, E_NONE, "short");
    for (int i = 0; i < 4; i++) add(1'b0, E_NONE, "short");
    add(1'b0, E_S, "short_fire");
    add(1'b0, E_NONE, "short_idle");

    // Double click: fires on the second release, no short afterwards.
    for (int i = 0; i < 2; i++) add(1'b1, E_NONE, "dbl");
    for (int i = 0; i < 2; i++) add(1'b0, E_NONE, "dbl");
    for (int i = 0; i < 2; i++) add(1'b1, E_NONE, "dbl");
    add(1'b0, E_D, "dbl_fire");
    for (int i = 0; i < 5; i++) add(1'b0, E_NONE, "dbl_idle");

    // Long press held 12 ticks.
    for (int i = 0; i < 7; i++) add(1'b1, E_NONE, "long");
    add(1'b1, E_LH, "long_fire");
    for (int i = 0; i < 4; i++) add(1'b1, E_H, "long_held");
    add(1'b0, E_NONE, "long_release");
    add(1'b0, E_NONE, "long_idle");

    // Release on the long-limit tick, then press on the gap-limit tick.
    for (int i = 0; i < 7; i++) add(1'b1, E_NONE, "race");
    add(1'b0, E_NONE, "race_rel_at_long_limit");
    for (int i = 0; i < 3; i++) add(1'b0, E_NONE, "race_gap");
    add(1'b1, E_NONE, "race_press_at_gap_limit");
    add(1'b0, E_D, "race_dbl");
    add(1'b0, E_NONE, "race_idle");

    do_reset(1'b0);
    foreach (tbl[i]) apply_tick(tbl[i].p, tbl[i].exp, $sformatf("%s[%0d]", tbl[i].name, i));

    // Reset mid-GAP aborts the gesture; a fresh click still works.
    apply_tick(1'b1, E_NONE, "rstgap_p0");
    apply_tick(1'b1, E_NONE, "rstgap_p1");
    apply_tick(1'b0, E_NONE, "rstgap_rel");
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) apply_tick(1'b0, E_NONE, $sformatf("rstgap_quiet[%0d]", i));
    apply_tick(1'b1, E_NONE, "fresh_p");
    apply_tick(1'b0, E_NONE, "fresh_rel");
    for (int i = 0; i < 3; i++) apply_tick(1'b0, E_NONE, $sformatf("fresh_gap[%0d]", i));
    apply_tick(1'b0, E_S, "fresh_short");

    // Button held through reset counts as a new press from the first tick.
    do_reset(1'b1);
    for (int i = 0; i < 7; i++) apply_tick(1'b1, E_NONE, $sformatf("held_rst[%0d]", i));
    apply_tick(1'b1, E_LH, "held_rst_long");
    apply_tick(1'b0, E_NONE, "held_rst_release");

    // Continuous tick, one-cycle glitch: PRESS1 then GAP, short 7 edges later.
    btn  = 1'b1;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    @(posedge clk); #1;
    check("glitch[0]", outs(), E_NONE);
    @(negedge clk);
    btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("glitch[%0d]", k), outs(), (k == 7) ? E_S : E_NONE);
    end
    @(negedge clk);
    tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
